// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states,
// radix legality check and iteration-count helper.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_e;

  function automatic bit radix_legal(int unsigned radix_bits);
    return (radix_bits == 1) || (radix_bits == 2) || (radix_bits == 4);
  endfunction

  function automatic int unsigned calc_iters(int unsigned width, int unsigned radix_bits);
    return width / radix_bits;
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain W-bit adder; carry out is dropped so sums wrap modulo 2^W.
module adder_nbit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul_seq_pp_gen.sv
// Partial product for one RADIX_BITS-wide multiplier digit, built as a sum
// of shifted copies of the multiplicand.
module mul_seq_pp_gen #(
  parameter int unsigned W          = 64,
  parameter int unsigned RADIX_BITS = 2
) (
  input  logic [W-1:0]          mcand_i,
  input  logic [RADIX_BITS-1:0] digit_i,
  output logic [W-1:0]          pp_o
);

  always_comb begin
    pp_o = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (digit_i[i]) begin
        pp_o = pp_o + (mcand_i << i);
      end
    end
  end

endmodule

// File: rtl/mul_seq_nbit.sv
// Iterative radix-2^RADIX_BITS signed/unsigned multiplier with valid/ready
// handshakes. Define MUL_SEQ_EARLY_TERM_EN to stop CALC once the multiplier is exhausted.
module mul_seq_nbit
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic [WIDTH-1:0]   P_LO
);

  localparam int unsigned ITERS = calc_iters(WIDTH, RADIX_BITS);
  localparam int unsigned CntW  = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  if (!radix_legal(RADIX_BITS) || (WIDTH < 2) || ((WIDTH % RADIX_BITS) != 0)) begin : g_param_err
    $fatal(1, "mul_seq_nbit: illegal WIDTH/RADIX_BITS combination");
  end

  mul_state_e      state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   p_q, p_d;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_shift;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             calc_last;

  // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude.
  assign a_mag        = (in_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag        = (in_signed && B[WIDTH-1]) ? -B : B;
  assign mplier_shift = mplier_q >> RADIX_BITS;

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign calc_last = (cnt_q == CntW'(ITERS - 1)) || (mplier_shift == '0);
`else
  assign calc_last = (cnt_q == CntW'(ITERS - 1));
`endif

  mul_seq_pp_gen #(
    .W          (PW),
    .RADIX_BITS (RADIX_BITS)
  ) u_pp_gen (
    .mcand_i (mcand_q),
    .digit_i (mplier_q[RADIX_BITS-1:0]),
    .pp_o    (pp)
  );

  adder_nbit #(
    .WIDTH (PW)
  ) u_acc_add (
    .a_i   (acc_q),
    .b_i   (pp),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (calc_last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        p_d     = neg_q ? -acc_q : acc_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = p_q;
  assign P_LO      = p_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_seq_nbit.sv
// Directed-vector bench for mul_seq_nbit at WIDTH=32, RADIX_BITS=2.
module tb_mul_seq_nbit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] P;
  logic [W-1:0]  P_LO;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_seq_nbit #(
    .WIDTH      (32),
    .RADIX_BITS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .P_LO      (P_LO)
  );

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Accept-to-out_valid latency expected for a given operand B.
  function automatic int exp_lat(input logic sgn, input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    logic [W-1:0] mb;
    int n;
    mb = (sgn && b[W-1]) ? -b : b;
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if ((mb >> (2 * i)) != '0) n = i + 1;
    end
    return n + 1;
`else
    return 17 + 0 * int'(sgn) + 0 * int'(b[0]);
`endif
  endfunction

  // Issue one operation and wait (bounded) for out_valid; returns latency.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = sgn;
    A         = a;
    B         = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A        = '1;
    B        = '1;
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_result(input logic [63:0] p_exp);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
    chk("idle_p_hold", P, p_exp);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB};
    vecs[2]  = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 64'h00000006FFFFFFEB};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000};
    vecs[4]  = '{1'b0, 32'h00000003, 32'h00000005, 64'h000000000000000F};
    vecs[5]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[6]  = '{1'b1, 32'h00000007, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFF9};
    vecs[7]  = '{1'b0, 32'h12345678, 32'h00000010, 64'h0000000123456780};
    vecs[8]  = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000};
    vecs[9]  = '{1'b0, 32'h00000001, 32'h00000000, 64'h0000000000000000};
    vecs[10] = '{1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vecs[12] = '{1'b0, 32'hDEADBEEF, 32'h00000001, 64'h00000000DEADBEEF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_p", P, 64'd0);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].sgn, vecs[i].b)));
      chk($sformatf("v%0d_p", i), P, vecs[i].p);
      chk($sformatf("v%0d_p_lo", i), {32'd0, P_LO}, {32'd0, vecs[i].p[31:0]});
      release_result(vecs[i].p);
    end

    // Backpressure: result must hold while the consumer stalls.
    issue(1'b0, 32'd5, 32'd6, lat);
    chk("bp_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd6)));
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_p", P, 64'd30);
      @(posedge clk);
      @(negedge clk);
    end
    release_result(64'd30);

    // Reset during CALC aborts the operation and clears P.
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = 1'b0;
    A         = 32'h0000FFFF;
    B         = 32'h0000FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_p", P, 64'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_err++;
        $display("FAIL abort_no_output: got out_valid 1, want 0");
      end
    end
    n_vec++;
    issue(1'b0, 32'd3, 32'd5, lat);
    chk("post_abort_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd5)));
    chk("post_abort_p", P, 64'd15);
    release_result(64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
